// File: rtl/sha3_bus_pkg.sv
// Shared state encoding and bus constants for the SHA3 bus initiator.
package sha3_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_ACK  = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_ACK  = 3'd4,
        ST_DIG_OUT = 3'd5
    } state_t;

    localparam logic [3:0] WSTRB_WRITE          = 4'hF;
    localparam logic [3:0] WSTRB_READ           = 4'h0;
    localparam int         DIGEST_WORDS_DEFAULT = 17;

endpackage

// File: rtl/sha3_bus_initiator.sv
// SHA3 slave-port initiator: writes each message word, then reads DIGEST_WORDS digest words back.
// Optional bus-ready timeout with sticky err is built when TIMEOUT_EN is defined.
module sha3_bus_initiator
    import sha3_bus_pkg::*;
#(
    parameter int BITS           = 32,
    parameter int DIGEST_WORDS   = DIGEST_WORDS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            msg_valid,
    input  logic [BITS-1:0] msg_data,
    input  logic            msg_last,
    output logic            msg_ready,
    output logic            valid,
    output logic [3:0]      wstrb,
    output logic [BITS-1:0] wdata,
    input  logic            ready,
    input  logic [BITS-1:0] rdata,
    output logic            dig_valid,
    output logic [BITS-1:0] dig_data,
    input  logic            dig_ready,
    output logic            busy,
    output logic            err,
    output logic [2:0]      dbg_state
);

    localparam int            CW      = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam logic [CW-1:0] LAST_RD = CW'(DIGEST_WORDS - 1);

    state_t          r_state;
    state_t          w_next;
    logic [BITS-1:0] r_word;
    logic [BITS-1:0] r_dig;
    logic            r_last;
    logic [CW-1:0]   r_rd_cnt;
    logic            w_idle_ready;
    logic            w_write;
    logic            w_req;
    logic            w_timeout;

    // RD_REQ is a quiet cycle so a read never starts right after the write/read ack.
    assign w_write = (r_state == ST_WR_REQ) || (r_state == ST_WR_ACK);
    assign w_req   = w_write || (r_state == ST_RD_ACK);

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_err;

    assign w_timeout = w_req && !ready && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_req && !ready && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_idle_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle_ready = 1'b1;
                if (msg_valid) w_next = ST_WR_REQ;
            end
            ST_WR_REQ, ST_WR_ACK: begin
                if (ready) begin
                    w_next = r_last ? ST_RD_REQ : ST_IDLE;
                end else begin
                    w_next = ST_WR_ACK;
                end
            end
            ST_RD_REQ: w_next = ST_RD_ACK;
            ST_RD_ACK: begin
                if (ready) w_next = ST_DIG_OUT;
            end
            ST_DIG_OUT: begin
                if (dig_ready) w_next = (r_rd_cnt == LAST_RD) ? ST_IDLE : ST_RD_REQ;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_timeout) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_word   <= '0;
            r_last   <= 1'b0;
            r_rd_cnt <= '0;
            r_dig    <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && msg_valid) begin
                r_word <= msg_data;
                r_last <= msg_last;
            end
            if ((r_state == ST_RD_ACK) && ready) begin
                r_dig <= rdata;
            end
            if (w_timeout || (w_write && ready)) begin
                r_rd_cnt <= '0;
            end else if ((r_state == ST_DIG_OUT) && dig_ready) begin
                r_rd_cnt <= (r_rd_cnt == LAST_RD) ? '0 : r_rd_cnt + 1'b1;
            end
        end
    end

    // msg_ready is gated by reset so every output reads 0 while reset is held.
    assign msg_ready = w_idle_ready && !reset;
    assign valid     = w_req;
    assign wstrb     = w_write ? WSTRB_WRITE : WSTRB_READ;
    assign wdata     = w_write ? r_word : '0;
    assign dig_valid = (r_state == ST_DIG_OUT);
    assign dig_data  = r_dig;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sha3_bus_initiator.sv
// Bench for sha3_bus_initiator: table-driven and random messages against a bus/digest model.
`timescale 1ns/1ps
module tb_sha3_bus_initiator;
  import sha3_bus_pkg::*;

  localparam int DW = 17;
  localparam int TO = 10;

  logic        clk = 1'b0, reset = 1'b1;
  logic        msg_valid = 1'b0, msg_last = 1'b0, ready = 1'b0, dig_ready = 1'b0;
  logic [31:0] msg_data = '0, rdata = '0;
  logic        msg_ready, valid, dig_valid, busy, err;
  logic [3:0]  wstrb;
  logic [31:0] wdata, dig_data;
  logic [2:0]  dbg_state;

  sha3_bus_initiator #(.BITS(32), .DIGEST_WORDS(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_last(msg_last), .msg_ready(msg_ready), .valid(valid), .wstrb(wstrb),
    .wdata(wdata), .ready(ready), .rdata(rdata), .dig_valid(dig_valid),
    .dig_data(dig_data), .dig_ready(dig_ready), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [35:0] exp_q[$];
  logic [31:0] exp_dig_q[$];
  logic [31:0] dig_log[$];
  int n_wr = 0, n_rd = 0, n_dig = 0;
  int ack_dly = 0, s_wait = 0, s_rd_n = 0;
  bit rand_rdata = 1'b1, force_pulse = 1'b0;
  logic [31:0] rd_base = '0;
  int cons_stall = 0, cons_hold = 0;
  bit cons_rand = 1'b0;
  bit dig_pend = 1'b0;
  logic [31:0] dig_prev = '0;

  typedef struct {
    int nw; logic [31:0] w0; int ack; int stall; bit crand; bit rrand;
    logic [31:0] rbase; bit gap; int exp_wr; int exp_rd;
  } vec_t;
  vec_t vecs[4];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Slave: acks a request ack_dly cycles after it appears, one-cycle ready pulse.
  always @(negedge clk) begin
    if (reset) begin
      ready = 1'b0; s_wait = 0;
    end else if (ready) begin
      ready = 1'b0; s_wait = 0;
    end else if (force_pulse) begin
      ready = 1'b1; force_pulse = 1'b0;
    end else if (valid) begin
      if (ack_dly >= 0 && s_wait >= ack_dly) begin
        ready = 1'b1;
        if (wstrb == WSTRB_WRITE) n_wr++;
        else begin
          n_rd++;
          rdata = rand_rdata ? $urandom : rd_base + 32'(s_rd_n);
          s_rd_n++;
          exp_dig_q.push_back(rdata);
        end
        if (exp_q.size() == 0) chk("bus_extra_txn", 1, 0);
        else chk("bus_txn", {wstrb, wdata}, exp_q.pop_front());
      end else begin
        s_wait++;
      end
    end
  end

  // Digest consumer side: scoreboard and hold-stable check.
  always @(negedge clk) begin
    if (reset) dig_pend = 1'b0;
    else begin
      if (dig_pend) chk("dig_hold", {dig_valid, dig_data}, {1'b1, dig_prev});
      if (dig_valid && dig_ready) begin
        n_dig++;
        dig_log.push_back(dig_data);
        if (exp_dig_q.size() == 0) chk("dig_extra", 1, 0);
        else chk("dig_word", dig_data, exp_dig_q.pop_front());
        cons_hold = cons_stall;
        dig_pend = 1'b0;
      end else if (dig_valid) begin
        dig_pend = 1'b1; dig_prev = dig_data;
      end else dig_pend = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (cons_hold > 0) begin
      dig_ready = 1'b0;
      if (dig_valid) cons_hold--;
    end else dig_ready = cons_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Bus protocol: gap after ack, request stable while outstanding.
  logic       p_valid = 1'b0;
  logic [3:0] p_wstrb = '0;
  logic [31:0] p_wdata = '0;
  always @(posedge clk) begin
    logic rdy_e;
    rdy_e = ready;
    #2;
    if (reset) p_valid = 1'b0;
    else begin
      if (p_valid && rdy_e) chk("bus_gap", valid, 0);
      else if (p_valid) begin
`ifndef TIMEOUT_EN
        chk("bus_hold_valid", valid, 1);
`endif
        if (valid) chk("bus_hold_req", {wstrb, wdata}, {p_wstrb, p_wdata});
      end
      p_valid = valid; p_wstrb = wstrb; p_wdata = wdata;
    end
  end

  task automatic send_msg(input int n, input logic [31:0] w0, input bit gap);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      int t;
      w = (i == 0) ? w0 : $urandom;
      if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      exp_q.push_back({WSTRB_WRITE, w});
      msg_valid = 1'b1; msg_data = w; msg_last = (i == n - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!msg_ready && t < 1000);
      if (t >= 1000) chk("msg_accept_bound", 0, 1);
      @(posedge clk); #1;
    end
    msg_valid = 1'b0; msg_last = 1'b0;
    for (int j = 0; j < DW; j++) exp_q.push_back({WSTRB_READ, 32'h0});
  endtask

  task automatic setup(input int ack, input int stall, input bit crand, input bit rrand,
                       input logic [31:0] rbase);
    ack_dly = ack; cons_stall = stall; cons_hold = stall; cons_rand = crand;
    rand_rdata = rrand; rd_base = rbase; s_rd_n = 0;
    n_wr = 0; n_rd = 0; n_dig = 0;
    dig_log.delete();
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int t;
    setup(v.ack, v.stall, v.crand, v.rrand, v.rbase);
    send_msg(v.nw, v.w0, v.gap);
    t = 0;
    while (!(n_dig == DW && !busy) && t < 5000) begin @(negedge clk); t++; end
    chk({name, "_done"}, t < 5000, 1);
    chk({name, "_writes"}, n_wr, v.exp_wr);
    chk({name, "_reads"}, n_rd, v.exp_rd);
    chk({name, "_digests"}, n_dig, v.exp_rd);
    chk({name, "_queues_empty"}, exp_q.size() + exp_dig_q.size(), 0);
    if (!v.rrand)
      for (int k = 0; k < dig_log.size(); k++)
        chk({name, "_seq_rdata"}, dig_log[k], v.rbase + 32'(k));
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit seen;
    vec_t rv;
    vecs[0] = '{1, 32'hDEADBEEF, 3, 0, 1'b0, 1'b1, 32'h0,    1'b0, 1, DW};
    vecs[1] = '{3, 32'hA5A50001, 0, 0, 1'b0, 1'b1, 32'h0,    1'b0, 3, DW};
    vecs[2] = '{1, 32'h12345678, 1, 5, 1'b0, 1'b0, 32'h1000, 1'b0, 1, DW};
    vecs[3] = '{5, 32'h0,        2, 0, 1'b1, 1'b1, 32'h0,    1'b1, 5, DW};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", {valid, wstrb, wdata}, 37'h0);
    chk("rst_dig", {dig_valid, dig_data}, 33'h0);
    chk("rst_flags", {msg_ready, busy, err, dbg_state}, 6'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_msg_ready", msg_ready, 1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv = '{$urandom_range(1, 6), $urandom, $urandom_range(0, 4), $urandom_range(0, 2),
             1'b1, 1'b1, 32'h0, 1'b1, 0, DW};
      rv.exp_wr = rv.nw;
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Async reset while read 8 is outstanding.
    setup(4, 0, 1'b0, 1'b1, 32'h0);
    send_msg(1, 32'hCAFEF00D, 1'b0);
    t = 0;
    while (!(valid && wstrb == WSTRB_READ && n_rd == 8) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("rd8_reached", t < 2000, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_outputs", {valid, dig_valid, busy, msg_ready}, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_dig_q.delete();
    run_vec(vecs[0], "after_rst");

    // Spurious ready while idle.
    force_pulse = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (dig_valid || busy || valid) seen = 1'b1;
    end
    chk("spurious_ready", {seen, dbg_state, msg_ready}, {1'b0, 3'd0, 1'b1});
    @(posedge clk); #1;

`ifdef TIMEOUT_EN
    setup(-1, 0, 1'b0, 1'b1, 32'h0);
    send_msg(1, 32'h0BADF00D, 1'b0);
    t = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) t++;
    end
    chk("timeout_valid_cycles", t, TO);
    chk("timeout_state", {valid, busy, err}, 3'b001);
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", err, 1);
    exp_q.delete();
    exp_dig_q.delete();
`else
    chk("err_tied_low", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
